ofifo_drain: RTL

Drain controller at the read end of the output FIFO. It pops complete rows of column partial sums from the ofifo whenever all columns hold data, optionally accumulates each row onto the value already stored in psum SRAM, and writes the result to psum SRAM at consecutive addresses. It sits between the ofifo and the psum SRAM, started by the top-level core controller once per tile.

---
 rtl/ofifo_drain_pkg.sv | 34 +++
 rtl/psum_sat_add.sv | 36 +++
 rtl/ofifo_drain.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ofifo_drain_pkg.sv
// rtl/ofifo_drain_pkg.sv - shared types, default sizes and saturation limits for the ofifo drain controller
// Purpose: state encoding for the drain FSM, default geometry (columns, lane
// width, SRAM address width, ofifo read latency) and the signed saturation
// limits used by the accumulate datapath.
// Ports: none (package).
package ofifo_drain_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int ADDR_BW = 11;
  localparam int RD_LAT  = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VALID,
    POP,
    WAIT_DATA,
    MEM_RD,
    ADD,
    WRITE,
    FINISH
  } state_t;

  // Largest positive value of a bw-bit two's complement lane: 2^(bw-1) - 1.
  function automatic logic signed [31:0] sat_max(input int bw);
    return (32'sd1 <<< (bw - 1)) - 32'sd1;
  endfunction

  // Most negative value of a bw-bit two's complement lane: -2^(bw-1).
  function automatic logic signed [31:0] sat_min(input int bw);
    return -(32'sd1 <<< (bw - 1));
  endfunction

endpackage

// File: rtl/psum_sat_add.sv
// rtl/psum_sat_add.sv - per-lane signed saturating adder for a row of partial sums
// Purpose: sum = sat(a + b) independently in each of COL lanes, signed
// two's complement, clamped to the lane range instead of wrapping.
// Ports:
//   a    in  COL*PSUM_BW  first operand row, lane i at [(i+1)*PSUM_BW-1 : i*PSUM_BW]
//   b    in  COL*PSUM_BW  second operand row, same lane layout
//   sum  out COL*PSUM_BW  saturated per-lane sum, same lane layout
module psum_sat_add
  import ofifo_drain_pkg::*;
#(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16
) (
  input  logic [COL*PSUM_BW-1:0] a,
  input  logic [COL*PSUM_BW-1:0] b,
  output logic [COL*PSUM_BW-1:0] sum
);

  localparam logic [PSUM_BW-1:0] MAX_V = PSUM_BW'(sat_max(PSUM_BW));
  localparam logic [PSUM_BW-1:0] MIN_V = PSUM_BW'(sat_min(PSUM_BW));

  for (genvar i = 0; i < COL; i++) begin : g_lane
    logic [PSUM_BW:0] ext;

    // One guard bit: sign-extend both operands so the true sum always fits.
    assign ext = {a[(i+1)*PSUM_BW-1], a[i*PSUM_BW +: PSUM_BW]}
               + {b[(i+1)*PSUM_BW-1], b[i*PSUM_BW +: PSUM_BW]};

    // Guard bit disagreeing with the lane sign bit means overflow; the guard
    // bit is the true sign, so it picks which rail to clamp to.
    assign sum[i*PSUM_BW +: PSUM_BW] =
      (ext[PSUM_BW] != ext[PSUM_BW-1]) ? (ext[PSUM_BW] ? MIN_V : MAX_V)
                                       : ext[PSUM_BW-1:0];
  end

endmodule

// File: rtl/ofifo_drain.sv
// rtl/ofifo_drain.sv - drains complete ofifo rows into psum SRAM, optionally accumulating
// Purpose: per job, pops num_rows rows from the ofifo whenever every column
// holds data, optionally adds each row to the value already in psum SRAM
// (saturating), and writes the result at base_addr, base_addr+1, ...
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   start             one-cycle job request, ignored while busy
//   num_rows          rows in the job (latched on start)
//   base_addr         first SRAM address (latched on start, wraps silently)
//   acc_en            1 = read-add-write, 0 = plain write (latched on start)
//   ofifo_valid       all ofifo columns non-empty
//   ofifo_rd          one-cycle pop request
//   ofifo_out         popped row, valid RD_LAT cycles after ofifo_rd
//   sram_cen/sram_wen active-low chip/write enables
//   sram_addr/sram_d  SRAM address and write data
//   sram_q            SRAM read data, valid the cycle after a read
//   busy              job in progress
//   done              one-cycle pulse when the job's last write completes
module ofifo_drain
  import ofifo_drain_pkg::*;
#(
  parameter int COL     = ofifo_drain_pkg::COL,
  parameter int PSUM_BW = ofifo_drain_pkg::PSUM_BW,
  parameter int ADDR_BW = ofifo_drain_pkg::ADDR_BW,
  parameter int RD_LAT  = ofifo_drain_pkg::RD_LAT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_BW-1:0]     num_rows,
  input  logic [ADDR_BW-1:0]     base_addr,
  input  logic                   acc_en,
  input  logic                   ofifo_valid,
  output logic                   ofifo_rd,
  input  logic [COL*PSUM_BW-1:0] ofifo_out,
  output logic                   sram_cen,
  output logic                   sram_wen,
  output logic [ADDR_BW-1:0]     sram_addr,
  output logic [COL*PSUM_BW-1:0] sram_d,
  input  logic [COL*PSUM_BW-1:0] sram_q,
  output logic                   busy,
  output logic                   done
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t                 state, state_nxt;
  logic [ADDR_BW-1:0]     num_q, base_q, row_cnt;
  logic                   acc_q;
  logic [LAT_W-1:0]       lat_cnt;
  logic [COL*PSUM_BW-1:0] row_q, row_nxt, sum;
  logic [ADDR_BW-1:0]     addr_cur;
  logic                   lat_last, row_last;

  psum_sat_add #(.COL(COL), .PSUM_BW(PSUM_BW)) u_add (
    .a   (row_q),
    .b   (sram_q),
    .sum (sum)
  );

  assign addr_cur = base_q + row_cnt;
  assign lat_last = (lat_cnt == LAT_W'(RD_LAT - 1));
  // Extra bit so a full-range num_rows never aliases through counter wrap.
  assign row_last = ({1'b0, row_cnt} + {{ADDR_BW{1'b0}}, 1'b1}) == {1'b0, num_q};

  // ofifo_valid is only looked at in WAIT_VALID: it is stale between POP
  // and the end of the read latency.
  always_comb begin
    state_nxt = state;
    row_nxt   = row_q;
    case (state)
      IDLE:       if (start) state_nxt = (num_rows == '0) ? FINISH : WAIT_VALID;
      WAIT_VALID: if (ofifo_valid) state_nxt = POP;
      POP:        state_nxt = WAIT_DATA;
      WAIT_DATA: begin
        if (lat_last) begin
          row_nxt   = ofifo_out;
          state_nxt = acc_q ? MEM_RD : WRITE;
        end
      end
      MEM_RD:     state_nxt = ADD;
      ADD: begin
        row_nxt   = sum;
        state_nxt = WRITE;
      end
      WRITE:      state_nxt = row_last ? FINISH : WAIT_VALID;
      FINISH:     state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up
  // exactly with the cycle the FSM spends in the matching state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      num_q     <= '0;
      base_q    <= '0;
      acc_q     <= 1'b0;
      row_cnt   <= '0;
      lat_cnt   <= '0;
      row_q     <= '0;
      ofifo_rd  <= 1'b0;
      sram_cen  <= 1'b1;
      sram_wen  <= 1'b1;
      sram_addr <= '0;
      sram_d    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= state_nxt;
      row_q    <= row_nxt;
      ofifo_rd <= (state_nxt == POP);
      sram_cen <= !((state_nxt == MEM_RD) || (state_nxt == WRITE));
      sram_wen <= (state_nxt != WRITE);
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == FINISH);

      if ((state_nxt == MEM_RD) || (state_nxt == WRITE)) sram_addr <= addr_cur;
      if (state_nxt == WRITE) sram_d <= row_nxt;

      if ((state == IDLE) && start) begin
        num_q   <= num_rows;
        base_q  <= base_addr;
        acc_q   <= acc_en;
        row_cnt <= '0;
      end

      if (state == POP) lat_cnt <= '0;
      else if (state == WAIT_DATA) lat_cnt <= lat_cnt + LAT_W'(1);

      if (state == WRITE) row_cnt <= row_cnt + ADDR_BW'(1);
    end
  end

endmodule
